// File: rtl/alu_decode_stage.sv
// Decode stage for RV32I integer-ALU instructions (R-type, I-type ALU, LUI).
// It has a main output register and a one-entry skid register, so it can accept one beat per cycle behind a registered in_ready.
module alu_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_alu_op,
  output logic [XLEN-1:0] out_imm,
  output logic            out_src_b_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_illegal
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] imm;
    logic            src_b_imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            illegal;
  } beat_t;

  // funct7 = 0 mapping, which R-type and I-type share
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] f_rs1;
  logic [4:0] f_rs2;
  logic [4:0] f_rd;

  assign opcode = in_instr[6:0];
  assign f_rd   = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign f_rs1  = in_instr[19:15];
  assign f_rs2  = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  beat_t dec_next;
  logic  legal;

  always_comb begin
    dec_next    = '0;
    legal       = 1'b0;
    dec_next.pc = in_pc;
    case (opcode)
      OPC_R: begin
        dec_next.rs1 = f_rs1;
        dec_next.rs2 = f_rs2;
        dec_next.rd  = f_rd;
        if (funct7 == 7'h00) begin
          legal           = 1'b1;
          dec_next.alu_op = base_op(funct3);
        end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
          legal           = 1'b1;
          dec_next.alu_op = ALU_SUB;
        end else if (funct7 == 7'h20 && funct3 == 3'b101) begin
          legal           = 1'b1;
          dec_next.alu_op = ALU_SRA;
        end
      end
      OPC_I: begin
        dec_next.rs1       = f_rs1;
        dec_next.rd        = f_rd;
        dec_next.src_b_imm = 1'b1;
        case (funct3)
          3'b001: begin
            legal           = (funct7 == 7'h00);
            dec_next.alu_op = ALU_SLL;
            dec_next.imm    = {{(XLEN-5){1'b0}}, in_instr[24:20]};
          end
          3'b101: begin
            legal           = (funct7 == 7'h00) || (funct7 == 7'h20);
            dec_next.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
            dec_next.imm    = {{(XLEN-5){1'b0}}, in_instr[24:20]};
          end
          default: begin
            legal           = 1'b1;
            dec_next.alu_op = base_op(funct3);
            dec_next.imm    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
          end
        endcase
      end
      OPC_LUI: begin
        legal              = 1'b1;
        dec_next.alu_op    = ALU_ADD;
        dec_next.rd        = f_rd;
        dec_next.src_b_imm = 1'b1;
        dec_next.imm       = {in_instr[31:12], 12'h000};
      end
      default: legal = 1'b0;
    endcase

    // Illegal beats still carry their PC so execute can raise the trap
    if (!legal) begin
      dec_next         = '0;
      dec_next.pc      = in_pc;
      dec_next.illegal = 1'b1;
    end else begin
      dec_next.reg_write = (f_rd != 5'd0);
    end
  end

  beat_t main_reg;
  beat_t skid_reg;
  logic  main_valid_reg;
  logic  skid_valid_reg;
  logic  accept;
  logic  drain;

  assign in_ready = ~skid_valid_reg;
  assign accept   = in_valid & in_ready;
  assign drain    = main_valid_reg & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (flush) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (!main_valid_reg || drain) begin
      // The skid always holds the older beat, and in_ready is low while it is full
      if (skid_valid_reg) begin
        main_reg       <= skid_reg;
        main_valid_reg <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else if (accept) begin
        main_reg       <= dec_next;
        main_valid_reg <= 1'b1;
      end else begin
        main_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      skid_reg       <= dec_next;
      skid_valid_reg <= 1'b1;
    end
  end

  assign out_valid     = main_valid_reg;
  assign out_pc        = main_reg.pc;
  assign out_alu_op    = main_reg.alu_op;
  assign out_imm       = main_reg.imm;
  assign out_src_b_imm = main_reg.src_b_imm;
  assign out_rs1       = main_reg.rs1;
  assign out_rs2       = main_reg.rs2;
  assign out_rd        = main_reg.rd;
  assign out_reg_write = main_reg.reg_write;
  assign out_illegal   = main_reg.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Testbench for alu_decode_stage: a table of known encodings, hand-written kill sequences, then random traffic.
// A FIFO model holds the decoded beats; the stage is expected to behave like a two-deep queue.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  out_alu_op;
  logic [31:0] out_imm;
  logic        out_src_b_imm;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_illegal;

  always #5 clk = ~clk;

  alu_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_alu_op(out_alu_op), .out_imm(out_imm), .out_src_b_imm(out_src_b_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_illegal(out_illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [31:0] imm;
    logic        sbi;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } beat_t;

  typedef struct {
    logic [31:0] instr;
    beat_t       exp;
  } vec_t;

  beat_t q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    delivered = 0;
  bit    checking = 1'b0;

  function automatic beat_t actual();
    return {out_pc, out_alu_op, out_imm, out_src_b_imm, out_rs1, out_rs2, out_rd,
            out_reg_write, out_illegal};
  endfunction

  function automatic beat_t mk(logic [31:0] pc, logic [3:0] op, logic [31:0] imm, logic sbi,
                               logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic rw,
                               logic ill);
    return {pc, op, imm, sbi, rs1, rs2, rd, rw, ill};
  endfunction

  // Reference decoder built from the instruction-set rules
  function automatic beat_t ref_decode(logic [31:0] ins, logic [31:0] pc);
    beat_t      b;
    logic [3:0] ops_by_f3[8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         ok;
    ops_by_f3 = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd3, 4'd4};
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    b   = '0;
    ok  = 1'b0;
    b.pc = pc;
    if (opc == 7'h33) begin
      b.rs1 = ins[19:15];
      b.rs2 = ins[24:20];
      b.rd  = ins[11:7];
      if (f7 == 7'h00) begin
        ok = 1'b1;
        b.alu_op = ops_by_f3[f3];
      end else if (f7 == 7'h20 && f3 == 3'd0) begin
        ok = 1'b1;
        b.alu_op = 4'd1;
      end else if (f7 == 7'h20 && f3 == 3'd5) begin
        ok = 1'b1;
        b.alu_op = 4'd7;
      end
    end else if (opc == 7'h13) begin
      b.rs1 = ins[19:15];
      b.rd  = ins[11:7];
      b.sbi = 1'b1;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        ok = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
        b.alu_op = (f3 == 3'd1) ? 4'd5 : (f7 == 7'h20 ? 4'd7 : 4'd6);
        b.imm = 32'(ins[24:20]);
      end else begin
        ok = 1'b1;
        b.alu_op = ops_by_f3[f3];
        b.imm = 32'($signed(ins[31:20]));
      end
    end else if (opc == 7'h37) begin
      ok = 1'b1;
      b.rd  = ins[11:7];
      b.sbi = 1'b1;
      b.imm = ins & 32'hFFFF_F000;
    end
    if (!ok) begin
      b = '0;
      b.pc = pc;
      b.ill = 1'b1;
    end else begin
      b.rw = (b.rd != 5'd0);
    end
    return b;
  endfunction

  task automatic chk_bit(input string nm, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0b required=%0b", nm, cyc, got, exp);
    end
  endtask

  task automatic chk_beat(input string nm, input beat_t got, input beat_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, got, exp);
    end
  endtask

  // Check the outputs against the model, drive one cycle, then advance the model
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl, input logic rs, output logic acc);
    logic  cons;
    beat_t popped;
    if (checking) begin
      chk_bit("out_valid", out_valid, q.size() > 0);
      chk_bit("in_ready", in_ready, q.size() < 2);
      if (q.size() > 0) chk_beat("payload", actual(), q[0]);
    end
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    acc  = v && (q.size() < 2) && !rs;
    cons = ordy && (q.size() > 0) && !rs;
    @(posedge clk);
    #1;
    cyc++;
    if (rs) begin
      q.delete();
    end else begin
      if (cons) begin
        popped = q.pop_front();
        delivered++;
        $display("beat pc=%h op=%0d imm=%h rd=%0d ill=%0b", popped.pc, popped.alu_op,
                 popped.imm, popped.rd, popped.ill);
      end
      if (fl) q.delete();
      else if (acc) q.push_back(ref_decode(ins, pc));
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  f7;
    ins = $urandom;
    f7  = ($urandom_range(0, 2) == 0) ? 7'h20
        : (($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00);
    case ($urandom_range(0, 4))
      0, 1: begin ins[6:0] = 7'h33; ins[31:25] = f7; end
      2:    begin ins[6:0] = 7'h13; if ($urandom_range(0, 1) == 1) ins[31:25] = f7; end
      3:    ins[6:0] = 7'h37;
      default: ;
    endcase
    return ins;
  endfunction

  vec_t  tbl[12];
  beat_t zero_beat;

  // Hold four beats behind a stalled consumer, or kill two buffered beats with flush or reset
  task automatic stream4(input logic [31:0] base_pc);
    logic [31:0] seq_ins[4];
    int          idx;
    int          k;
    int          start;
    logic        acc;
    seq_ins = '{32'h002081B3, 32'h402081B3, 32'h4050D193, 32'h123451B7};
    idx = 0;
    k = 0;
    start = delivered;
    while ((idx < 4 || q.size() > 0) && k < 40) begin
      step(idx < 4, seq_ins[idx % 4], base_pc + 32'(idx * 4), k >= 3, 1'b0, 1'b0, acc);
      if (acc) idx++;
      k++;
    end
    chk_bit("stream_bound", k < 40, 1'b1);
    n_cmp++;
    if (delivered - start != 4) begin
      n_bad++;
      $display("FAIL stream_count actual=%0d required=4", delivered - start);
    end
  endtask

  task automatic kill_full(input logic use_rst);
    logic acc;
    step(1'b1, 32'h002081B3, 32'h200, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'h402081B3, 32'h204, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'h0020C1B3, 32'h208, 1'b0, !use_rst, use_rst, acc);
    chk_bit("kill_out_valid", out_valid, 1'b0);
    chk_bit("kill_in_ready", in_ready, 1'b1);
    step(1'b1, 32'h0020F1B3, 32'h20C, 1'b1, 1'b0, 1'b0, acc);
    chk_beat("kill_next", actual(), mk(32'h20C, 4'd4, 0, 0, 1, 2, 3, 1, 0));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
  endtask

  initial begin
    logic acc;
    zero_beat = '0;
    tbl[0]  = '{32'h002081B3, mk(32'h000, 4'd0, 32'h0,        0, 1, 2, 3, 1, 0)};
    tbl[1]  = '{32'h402081B3, mk(32'h004, 4'd1, 32'h0,        0, 1, 2, 3, 1, 0)};
    tbl[2]  = '{32'h4050D193, mk(32'h008, 4'd7, 32'h5,        1, 1, 0, 3, 1, 0)};
    tbl[3]  = '{32'hFFF08193, mk(32'h00C, 4'd0, 32'hFFFFFFFF, 1, 1, 0, 3, 1, 0)};
    tbl[4]  = '{32'h123451B7, mk(32'h010, 4'd0, 32'h12345000, 1, 0, 0, 3, 1, 0)};
    tbl[5]  = '{32'h602081B3, mk(32'h014, 4'd0, 32'h0,        0, 0, 0, 0, 0, 1)};
    tbl[6]  = '{32'h00208063, mk(32'h018, 4'd0, 32'h0,        0, 0, 0, 0, 0, 1)};
    tbl[7]  = '{32'h00208033, mk(32'h01C, 4'd0, 32'h0,        0, 1, 2, 0, 0, 0)};
    tbl[8]  = '{32'h0020C1B3, mk(32'h020, 4'd2, 32'h0,        0, 1, 2, 3, 1, 0)};
    tbl[9]  = '{32'h00509193, mk(32'h024, 4'd5, 32'h5,        1, 1, 0, 3, 1, 0)};
    tbl[10] = '{32'h02509193, mk(32'h028, 4'd0, 32'h0,        0, 0, 0, 0, 0, 1)};
    tbl[11] = '{32'h8000B193, mk(32'h02C, 4'd9, 32'hFFFFF800, 1, 1, 0, 3, 1, 0)};

    in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0; rst = 1'b1;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    checking = 1'b1;
    chk_bit("reset_out_valid", out_valid, 1'b0);
    chk_bit("reset_in_ready", in_ready, 1'b1);
    chk_beat("reset_data", actual(), zero_beat);

    // Back-to-back decode with out_ready high: one beat per cycle
    for (int i = 0; i < 12; i++) begin
      step(1'b1, tbl[i].instr, tbl[i].exp.pc, 1'b1, 1'b0, 1'b0, acc);
      chk_beat("vector", actual(), tbl[i].exp);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

    stream4(32'h100);
    kill_full(1'b0);
    kill_full(1'b1);

    // Flush while draining the main register: the consumed beat counts, the accepted beat is dropped
    step(1'b1, 32'h00208033, 32'h300, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'h0020C1B3, 32'h304, 1'b1, 1'b1, 1'b0, acc);
    chk_bit("flush_drain_valid", out_valid, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0, acc);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
    chk_bit("final_empty", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
Registered decode stage that turns RISC-V RV32I integer-ALU instructions (R-type, I-type ALU, LUI) into the 4-bit alu_op code and operand controls consumed by the ALU in the execute stage. It sits between fetch and execute and uses valid/ready handshakes on both sides. A 2-entry skid buffer sustains 1 instruction/cycle with a registered in_ready.

Parameters:
XLEN, 32, instruction/PC/immediate width (only 32 supported)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous kill of all buffered instructions
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept; registered, equals ~skid_full
in_instr  in  32  instruction word
in_pc  in  32  instruction address
out_valid  out  1  decoded beat available
out_ready  in  1  execute accepts the beat
out_pc  out  32  PC of the decoded beat
out_alu_op  out  4  ADD=0 SUB=1 XOR=2 OR=3 AND=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9
out_imm  out  32  immediate for operand B
out_src_b_imm  out  1  1: ALU B = out_imm; 0: ALU B = rs2 data
out_rs1  out  5  source register 1 (forced 0 for LUI)
out_rs2  out  5  source register 2 (0 when unused)
out_rd  out  5  destination register
out_reg_write  out  1  write rd; 0 when rd==0 or illegal
out_illegal  out  1  unsupported or malformed encoding

Behaviour:
- Reset (rst=1): out_valid=0, skid empty, in_ready=1 next cycle; all data outputs 0. rst has priority over flush and handshakes.
- Transfer rules: input beat accepted when in_valid&in_ready; output beat consumed when out_valid&out_ready. Output payload holds stable while out_valid&~out_ready.
- Latency: an instruction accepted in cycle N is on the outputs at cycle N+1 when the main register is empty or drains in cycle N.
- Skid: if the main register is full and not draining, an accepted beat goes to the skid register; in_ready drops the next cycle. When the main register drains, the skid moves to main the same edge and in_ready returns to 1. Order is strictly FIFO; no beat is lost or duplicated.
- Decoding is combinational on the input and registered into main/skid.
- Flush: next cycle out_valid=0, skid empty, in_ready=1. A beat accepted in the flush cycle is discarded. A beat consumed in the flush cycle is still counted as delivered.
- Opcode 0110011 (R): funct7=0x00 maps funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND. funct7=0x20 is legal only for funct3 000 (SUB) and 101 (SRA). src_b_imm=0, imm=0.
- Opcode 0010011 (I): funct3 000 ADDI, 010 SLTI, 011 SLTIU, 100 XORI, 110 ORI, 111 ANDI, with imm = sign-extended instr[31:20].
  - 001 SLLI requires instr[31:25]=0.
  - 101 requires instr[31:25]=0x00 (SRLI) or 0x20 (SRAI).
  - Shifts: imm = zero-extended instr[24:20].
  - All I-type: src_b_imm=1, rs2=0.
- Opcode 0110111 (LUI): alu_op=ADD, rs1=0, rs2=0, imm={instr[31:12],12'h000}, src_b_imm=1.
- Any other opcode or malformed funct field: out_illegal=1, alu_op=ADD, reg_write=0, imm=0, rs1/rs2/rd=0. The beat still passes through the handshake.
- rd==0 on a legal instruction: reg_write=0, beat still delivered.

Test Plan:
- Back-to-back, out_ready=1: 0x002081B3 (add x3,x1,x2) then 0x402081B3 (sub) -> out alu_op 0 then 1 on consecutive cycles; rs1=1, rs2=2, rd=3, reg_write=1; one beat/cycle.
- 0x4050D193 (srai x3,x1,5) -> alu_op=7, imm=0x00000005, src_b_imm=1; 0xFFF08193 (addi x3,x1,-1) -> alu_op=0, imm=0xFFFFFFFF.
- 0x123451B7 (lui x3,0x12345) -> alu_op=0, rs1=0, imm=0x12345000, src_b_imm=1.
- Illegal: 0x602081B3 (funct7 0x30) and opcode 0x63 -> out_illegal=1, reg_write=0, alu_op=0; 0x00208033 (add x0) -> legal, reg_write=0.
- Backpressure: stream 4 instructions with in_valid=1 and out_ready low for 3 cycles -> in_ready falls one cycle after the skid fills; all 4 emerge in order, none dropped or duplicated.
- Flush with main and skid full plus in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed beats never appear. Repeat the sequence with rst instead of flush; the result must be identical.
